pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Stateful hazard and pipeline-control unit for the 5-stage MIPS datapath. It replaces the forwarding-only hazard check with a unit that provides:
- forwarding selects;
- load-use stall;
- branch flush;
- multi-cycle EX occupancy (mult/div-style ops).

It tracks the destination, regwrite and memtoreg of in-flight instructions in its own EX/MEM/WB shadow slots. The datapath feeds it ID-stage decode info and consumes its stall, flush and forward outputs.

Parameters:
REGW, 5, register-address width
MCYC, 4, EX latency in cycles of a multi-cycle op (>=2)
CNTW, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REGW  ID source register A
id_rt  in  REGW  ID source register B
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_dst  in  REGW  ID destination (already regdst-muxed)
id_regwrite  in  1  ID instruction writes the register file
id_memtoreg  in  1  ID instruction is a load
id_multi  in  1  ID instruction is a multi-cycle EX op
branch_taken_mem  in  1  branch in MEM resolved taken (pcsrc)
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
bubble_e  out  1  load zeros/no-op into ID/EX at next edge
flush_d  out  1  clear IF/ID
flush_e  out  1  clear ID/EX
flush_m  out  1  clear EX/MEM
ex_busy  out  1  multi-cycle op occupying EX
fwd_a  out  2  EX srcA select: 00 regfile, 01 WB result, 10 MEM aluout
fwd_b  out  2  EX srcB select, same encoding
stall_cycles  out  CNTW  saturating count of cycles with stall_f=1

Behaviour:
- Reset (async, high):
  - all shadow slots invalid, multi counter 0, stall_cycles 0.
  - all 1-bit outputs 0; fwd_a and fwd_b are 00.
- Shadow slots:
  - EX slot holds {valid, rs, rt, use_rs, use_rt, dst, regwrite, memtoreg}.
  - MEM and WB slots hold {valid, dst, regwrite, memtoreg}.
- "Writer" means a slot with valid=1, regwrite=1 and dst!=0. Register 0 never causes a stall or a forward.
- Forwarding is combinational from the slots. It applies to the EX-slot rs when use_rs=1, and the same rule applies to rt/fwd_b:
  - MEM writer with dst==rs gives 10;
  - otherwise WB writer with dst==rs gives 01;
  - otherwise 00.
  - MEM has priority over WB.
- Load-use hazard (lu): EX writer has memtoreg=1 and id_valid=1, and either (id_use_rs and id_rs==EX.dst) or (id_use_rt and id_rt==EX.dst).
- Multi-cycle op:
  - When an id_multi instruction enters EX, the counter loads MCYC-1.
  - ex_busy = (counter!=0).
  - While busy, the counter decrements each cycle and the EX slot holds.
  - MEM receives a bubble each busy cycle.
  - The op advances to MEM on the edge after the counter reaches 0. Total EX residency is MCYC cycles.
- Outputs:
  - stall_f = stall_d = (lu | ex_busy) & ~branch_taken_mem.
  - bubble_e = lu & ~ex_busy & ~branch_taken_mem.
  - flush_d = flush_e = flush_m = branch_taken_mem.
- Slot update at each edge, in priority order:
  1. branch_taken_mem: EX and MEM slots invalidated. The counter is cleared, which kills an in-progress multi op (it is younger than the branch). WB receives the old MEM slot.
  2. ex_busy: EX holds, MEM invalid, WB takes old MEM.
  3. lu: EX invalid (bubble), MEM takes old EX, WB takes old MEM.
  4. Otherwise: EX takes the ID inputs (valid=id_valid), MEM takes old EX, WB takes old MEM.
- A load in EX followed by a multi op in ID that uses the load result: lu stalls 1 cycle, then the multi op enters EX normally.
- stall_cycles increments on each edge where stall_f=1. It saturates at all-ones and does not wrap.
- Reset mid-multi-op aborts it immediately; ex_busy drops asynchronously.

Test Plan:
1. Forwarding: `add $3,$1,$2` then `sub $4,$3,$5` back-to-back. With sub in EX: fwd_a=10, fwd_b=00. Insert one unrelated instruction between them: fwd_a=01. With dst=$0 in both cases: fwd_a=00.
2. Load-use: `lw $2,0($1)` then `add $4,$2,$2`.
   - Exactly 1 cycle of stall_f=stall_d=bubble_e=1.
   - Then the add sits in EX with fwd_a=fwd_b=01.
   - stall_cycles=1.
   - A `lw` followed by an add that does not read $2 causes no stall.
3. Multi-cycle, MCYC=4: a multi op enters EX.
   - ex_busy=1 for 3 cycles, with stall_f=1 on the same 3 cycles.
   - MEM slot invalid on those cycles; the op reaches MEM on the 4th edge.
   - stall_cycles=3.
4. Branch flush: branch_taken_mem pulsed 1 cycle while the EX slot holds a writer to $7.
   - flush_d/e/m=1 for that cycle.
   - The following cycle: fwd_a=fwd_b=00 for $7 (the killed writer is not forwarded).
5. Branch during multi-op: branch_taken_mem asserted 2 cycles into an MCYC=4 op → ex_busy=0 and stall_f=0 from the next edge; the counter is cleared.
6. Saturation and reset: with CNTW=4, hold a multi-op stream for more than 15 stall cycles → stall_cycles stays at 15. Assert reset asynchronously mid-op → ex_busy=0 and stall_cycles=0 before the next clk edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS datapath: forwarding selects,
// load-use stall, branch flush and multi-cycle EX occupancy from shadow EX/MEM/WB slots.
module pipeline_ctrl #(
  parameter int REGW = 5,
  parameter int MCYC = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [REGW-1:0] id_dst,
  input  logic            id_regwrite,
  input  logic            id_memtoreg,
  input  logic            id_multi,
  input  logic            branch_taken_mem,
  output logic            stall_f,
  output logic            stall_d,
  output logic            bubble_e,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_m,
  output logic            ex_busy,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [CNTW-1:0] stall_cycles
);

  localparam int CW = $clog2(MCYC);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MCYC - 1);

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic            use_rs;
    logic            use_rt;
    logic [REGW-1:0] dst;
    logic            regwrite;
    logic            memtoreg;
  } ex_slot_t;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] dst;
    logic            regwrite;
    logic            memtoreg;
  } mw_slot_t;

  ex_slot_t      ex_q;
  ex_slot_t      id_slot;
  mw_slot_t      mem_q;
  mw_slot_t      wb_q;
  mw_slot_t      ex_as_mw;
  logic [CW-1:0] mcnt;
  logic          ex_wr;
  logic          mem_wr;
  logic          wb_wr;
  logic          lu;

  always_comb begin
    id_slot.valid    = id_valid;
    id_slot.rs       = id_rs;
    id_slot.rt       = id_rt;
    id_slot.use_rs   = id_use_rs;
    id_slot.use_rt   = id_use_rt;
    id_slot.dst      = id_dst;
    id_slot.regwrite = id_regwrite;
    id_slot.memtoreg = id_memtoreg;

    ex_as_mw.valid    = ex_q.valid;
    ex_as_mw.dst      = ex_q.dst;
    ex_as_mw.regwrite = ex_q.regwrite;
    ex_as_mw.memtoreg = ex_q.memtoreg;
  end

  // A writer to $0 is architecturally a no-op, so it never stalls or forwards.
  assign ex_wr  = ex_q.valid  & ex_q.regwrite  & (ex_q.dst  != '0);
  assign mem_wr = mem_q.valid & mem_q.regwrite & (mem_q.dst != '0);
  assign wb_wr  = wb_q.valid  & wb_q.regwrite  & (wb_q.dst  != '0);

  assign lu = ex_wr & ex_q.memtoreg & id_valid &
              ((id_use_rs & (id_rs == ex_q.dst)) | (id_use_rt & (id_rt == ex_q.dst)));

  assign ex_busy  = (mcnt != '0);
  assign stall_f  = (lu | ex_busy) & ~branch_taken_mem;
  assign stall_d  = stall_f;
  assign bubble_e = lu & ~ex_busy & ~branch_taken_mem;
  assign flush_d  = branch_taken_mem;
  assign flush_e  = branch_taken_mem;
  assign flush_m  = branch_taken_mem;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_q.use_rs) begin
      if (mem_wr && (mem_q.dst == ex_q.rs))    fwd_a = 2'b10;
      else if (wb_wr && (wb_q.dst == ex_q.rs)) fwd_a = 2'b01;
    end
    if (ex_q.use_rt) begin
      if (mem_wr && (mem_q.dst == ex_q.rt))    fwd_b = 2'b10;
      else if (wb_wr && (wb_q.dst == ex_q.rt)) fwd_b = 2'b01;
    end
  end

  // Branch kills EX/MEM and any in-progress multi op; busy holds EX and feeds MEM bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      mcnt         <= '0;
      stall_cycles <= '0;
    end else begin
      wb_q <= mem_q;
      if (branch_taken_mem) begin
        ex_q  <= '0;
        mem_q <= '0;
        mcnt  <= '0;
      end else if (ex_busy) begin
        mem_q <= '0;
        mcnt  <= mcnt - CW'(1);
      end else if (lu) begin
        mem_q <= ex_as_mw;
        ex_q  <= '0;
      end else begin
        mem_q <= ex_as_mw;
        ex_q  <= id_slot;
        if (id_valid && id_multi) mcnt <= CNT_LOAD;
      end
      if (stall_f && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNTW'(1);
    end
  end

endmodule
